// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mdu_sequencer
// Purpose  : Multi-cycle sequencer for the E-stage multiply/divide unit and
//            its architectural HI/LO register pair. One mult/multu/div/divu/
//            mthi/mtlo request is accepted per start pulse while idle. The
//            result is computed from the start-cycle operands, then held
//            while a fixed latency is counted out, and committed to HI/LO
//            when the count expires.
// Ports    : clk     - clock, rising edge
//            reset   - synchronous active-high reset
//            start   - one-cycle request strobe
//            mdu_op  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
//            d1, d2  - rs / rt operands
//            cancel  - abort request (honoured only with MDU_CANCEL_EN)
//            busy    - operation in flight (registered)
//            done    - one-cycle pulse in the cycle HI/LO commit (registered)
//            hi, lo  - architectural HI / LO
// Config   : `define MDU_CANCEL_EN to enable the cancel input.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic        res_valid_q, res_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic w_cancel;
`ifdef MDU_CANCEL_EN
  assign w_cancel = cancel;
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign w_cancel      = 1'b0;
`endif

  // Arithmetic on the start-cycle operands.
  logic        sdiv;
  logic [63:0] mul_res;
  logic [31:0] div_a, div_b, div_q, div_r, quot, rem;

  always_comb begin
    // Signed multiply via sign extension: the low 64 bits of the widened
    // unsigned product equal the two's-complement signed product.
    if (mdu_op == OP_MULT)
      mul_res = {{32{d1[31]}}, d1} * {{32{d2[31]}}, d2};
    else
      mul_res = {32'd0, d1} * {32'd0, d2};

    // Signed divide runs on magnitudes through one unsigned divider, then
    // fixes signs: quotient truncates toward zero, remainder follows d1.
    // 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
    sdiv  = (mdu_op == OP_DIV);
    div_a = (sdiv && d1[31]) ? -d1 : d1;
    div_b = (sdiv && d2[31]) ? -d2 : d2;
    if (div_b == 32'd0)
      div_b = 32'd1;  // keeps the divider defined; result is discarded
    div_q = div_a / div_b;
    div_r = div_a % div_b;
    quot  = (sdiv && (d1[31] ^ d2[31])) ? -div_q : div_q;
    rem   = (sdiv && d1[31]) ? -div_r : div_r;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_hi_d    = res_hi_q;
    res_lo_d    = res_lo_q;
    res_valid_d = res_valid_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    hi_d        = hi_q;
    lo_d        = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start && !w_cancel) begin
          case (mdu_op)
            OP_MULT, OP_MULTU: begin
              res_hi_d    = mul_res[63:32];
              res_lo_d    = mul_res[31:0];
              res_valid_d = 1'b1;
              cnt_d       = MULT_LOAD;
              state_d     = S_RUN;
              busy_d      = 1'b1;
              done_d      = (MULT_CYCLES == 1);
            end
            OP_DIV, OP_DIVU: begin
              res_hi_d    = rem;
              res_lo_d    = quot;
              res_valid_d = (d2 != 32'd0);  // divide by zero leaves HI/LO alone
              cnt_d       = DIV_LOAD;
              state_d     = S_RUN;
              busy_d      = 1'b1;
              done_d      = (DIV_CYCLES == 1);
            end
            OP_MTHI: hi_d = d1;
            OP_MTLO: lo_d = d1;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (w_cancel) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          if (res_valid_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
          state_d = S_IDLE;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          busy_d = 1'b1;
          // done is registered, so it is raised one cycle ahead of cnt==0.
          done_d = (cnt_q == 4'd1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      res_hi_q    <= 32'd0;
      res_lo_q    <= 32'd0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_hi_q    <= res_hi_d;
      res_lo_q    <= res_lo_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_sequencer
// Purpose  : Directed, table-driven bench for mdu_sequencer plus hand-written
//            sequences for reset, RUN-time start and cancel behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] d1, d2;
  logic        cancel;
  logic        busy, done;
  logic [31:0] hi, lo;

  mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdu_op (mdu_op),
    .d1     (d1),
    .d2     (d2),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Per-operation observation counters, sampled on the falling edge.
  int busy_cnt = 0;
  int done_cnt = 0;
  int done_idx = 0;

  always @(negedge clk) begin
    if (busy) busy_cnt = busy_cnt + 1;
    if (done) begin
      done_cnt = done_cnt + 1;
      done_idx = busy_cnt;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one start pulse; returns #1 after the start edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    busy_cnt = 0;
    done_cnt = 0;
    done_idx = 0;
    start    = 1'b1;
    mdu_op   = op;
    d1       = a;
    d2       = b;
    @(posedge clk); #1;
    start  = 1'b0;
    mdu_op = 4'd0;
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while (busy && g < 40) begin
      @(posedge clk); #1;
      g++;
    end
    if (busy) begin
      n_total++;
      $display("FAIL %s: busy still %b after %0d cycles, required 0", name, busy, g);
    end
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[12];

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    mdu_op = 4'd0;
    d1     = 32'd0;
    d2     = 32'd0;
    cancel = 1'b0;

    vecs[0]  = '{"mult_neg",   4'd1, 32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{"multu",      4'd2, 32'hFFFFFFFE, 32'd3,        5,  32'h00000002, 32'hFFFFFFFA};
    vecs[2]  = '{"div_neg",    4'd3, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"divu_by0",   4'd4, 32'd7,        32'd0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{"div_ovf",    4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
    vecs[5]  = '{"divu",       4'd4, 32'd100,      32'd7,        10, 32'h00000002, 32'h0000000E};
    vecs[6]  = '{"mthi",       4'd5, 32'h12345678, 32'd9,        0,  32'h12345678, 32'h0000000E};
    vecs[7]  = '{"mtlo",       4'd6, 32'hCAFEBABE, 32'd9,        0,  32'h12345678, 32'hCAFEBABE};
    vecs[8]  = '{"mult_max",   4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 5,  32'h3FFFFFFF, 32'h00000001};
    vecs[9]  = '{"div_negd2",  4'd3, 32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
    vecs[10] = '{"op_none",    4'd0, 32'h55555555, 32'd3,        0,  32'h00000001, 32'hFFFFFFFD};
    vecs[11] = '{"op_undef",   4'd9, 32'h55555555, 32'd3,        0,  32'h00000001, 32'hFFFFFFFD};

    // Reset state.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    // Table-driven operations.
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_idle({vecs[i].name, "_timeout"});
      chk({vecs[i].name, "_busy_cycles"}, busy_cnt, vecs[i].n);
      chk({vecs[i].name, "_done_count"}, done_cnt, (vecs[i].n > 0) ? 1 : 0);
      if (vecs[i].n > 0)
        chk({vecs[i].name, "_done_pos"}, done_idx, vecs[i].n);
      chk({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
      chk({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
    end

    // mtlo issued while a mult is running must be ignored.
    issue(4'd1, 32'd2, 32'd3);
    @(posedge clk); #1;
    start = 1'b1; mdu_op = 4'd6; d1 = 32'hDEADBEEF;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = 4'd0;
    chk("run_mtlo_lo_now", lo, 32'hFFFFFFFD);
    wait_idle("run_mtlo_timeout");
    chk("run_mtlo_busy_cycles", busy_cnt, 5);
    chk("run_mtlo_hi", hi, 32'h00000000);
    chk("run_mtlo_lo", lo, 32'h00000006);

    // Reset in busy cycle 3 aborts the mult and clears HI/LO.
    issue(4'd1, 32'd5, 32'd5);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    repeat (4) begin @(posedge clk); #1; end
    chk("rst_mid_no_done", done_cnt, 0);
    chk("rst_mid_busy_later", {31'd0, busy}, 32'd0);

    // Cancel in busy cycle 4 of a div.
    issue(4'd5, 32'h11111111, 32'd0);
    issue(4'd6, 32'h22222222, 32'd0);
    issue(4'd3, 32'd100, 32'd7);
    repeat (3) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
`ifdef MDU_CANCEL_EN
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    chk("cancel_hi", hi, 32'h11111111);
    chk("cancel_lo", lo, 32'h22222222);
    repeat (8) begin @(posedge clk); #1; end
    chk("cancel_no_done", done_cnt, 0);
    chk("cancel_hi_later", hi, 32'h11111111);
`else
    wait_idle("cancel_ign_timeout");
    chk("cancel_ign_busy_cycles", busy_cnt, 10);
    chk("cancel_ign_done", done_cnt, 1);
    chk("cancel_ign_hi", hi, 32'h00000002);
    chk("cancel_ign_lo", lo, 32'h0000000E);
`endif

    // cancel together with start in IDLE.
    cancel = 1'b1;
    issue(4'd5, 32'hABCD0000, 32'd0);
    cancel = 1'b0;
`ifdef MDU_CANCEL_EN
    chk("cancel_start_hi", hi, 32'h11111111);
`else
    chk("cancel_start_hi", hi, 32'hABCD0000);
`endif
    chk("cancel_start_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
